msg_schedule_param: RTL

//  Parametrised SHA-2 message schedule generator. Accepts one 16-word padded block and streams W[0..ROUNDS-1]
//  one word per accepted handshake to the compression round engine.

---
 rtl/msg_schedule_param.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/msg_schedule_param.sv
// msg_schedule_param
//   SHA-2 message schedule generator for SHA-224/256 (WORD_W=32, ROUNDS=64)
//   and SHA-384/512 (WORD_W=64, ROUNDS=80). It loads one 16-word padded
//   block and streams W[0..ROUNDS-1], one word per accepted handshake.
//   A 16-entry circular buffer holds the sliding window W[t-16..t-1].
//   Optional feature macro: MSG_SCHED_BACKPRESSURE_EN. When it is defined,
//   word_ready_in gates advance. When it is not defined, one word is
//   produced every RUN cycle and word_ready_in is ignored.
module msg_schedule_param #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_in,
    input  logic [16*WORD_W-1:0]  block_in,
    input  logic                  word_ready_in,
    output logic [WORD_W-1:0]     word_out,
    output logic                  word_valid_out,
    output logic [6:0]            round_out,
    output logic [1:0]            state_out,
    output logic                  busy_out,
    output logic                  done_out
);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("msg_schedule_param: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > 127) begin : g_bad_rounds
        $error("msg_schedule_param: ROUNDS must be in 16..127");
    end

    // Rotate and shift amounts for the two small sigma functions.
    localparam int unsigned S0_R1 = (WORD_W == 32) ? 7  : 1;
    localparam int unsigned S0_R2 = (WORD_W == 32) ? 18 : 8;
    localparam int unsigned S0_SH = (WORD_W == 32) ? 3  : 7;
    localparam int unsigned S1_R1 = (WORD_W == 32) ? 17 : 19;
    localparam int unsigned S1_R2 = (WORD_W == 32) ? 19 : 61;
    localparam int unsigned S1_SH = (WORD_W == 32) ? 10 : 6;

    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    state_t             state_q, state_d;
    logic [6:0]         round_q, round_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [WORD_W-1:0]  sched_buf [16];
    logic               load;
    logic               buf_we;
    logic               advance;
    logic [6:0]         t_next;
    logic [3:0]         t_idx;
    logic [WORD_W-1:0]  w_new;

`ifdef MSG_SCHED_BACKPRESSURE_EN
    assign advance = word_ready_in;
`else
    logic unused_ready;
    assign unused_ready = word_ready_in;
    assign advance      = 1'b1;
`endif

    // Index of the next word; 4-bit arithmetic on t_idx wraps mod 16,
    // which is exactly the circular-buffer addressing of W[t-k].
    assign t_next = round_q + 7'd1;
    assign t_idx  = t_next[3:0];
    assign w_new  = sig1(sched_buf[t_idx - 4'd2]) + sched_buf[t_idx - 4'd7]
                  + sig0(sched_buf[t_idx - 4'd15]) + sched_buf[t_idx];

    // Next-state, next-round and next-word selection.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; a missing default infers a latch.
        state_d = state_q;
        round_d = round_q;
        word_d  = word_q;
        load    = 1'b0;
        buf_we  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_in) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                    round_d = 7'd0;
                    word_d  = block_in[16*WORD_W-1 -: WORD_W];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = ST_DONE;
                    end else begin
                        round_d = t_next;
                        if (t_next < 7'd16) begin
                            word_d = sched_buf[t_idx];
                        end else begin
                            word_d = w_new;
                            buf_we = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = 7'd0;
                word_d  = '0;
            end
        endcase
    end

    // State, output registers and the schedule window buffer.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values, independent of order.
        if (!RST) begin
            state_q <= ST_IDLE;
            round_q <= 7'd0;
            word_q  <= '0;
            // NOTE: the window buffer is explicitly cleared on reset so no
            // stale block data survives an aborted run; it is only 16 words.
            for (int i = 0; i < 16; i++) begin
                sched_buf[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            word_q  <= word_d;
            if (load) begin
                for (int i = 0; i < 16; i++) begin
                    sched_buf[i] <= block_in[(15-i)*WORD_W +: WORD_W];
                end
            end else if (buf_we) begin
                sched_buf[t_idx] <= w_new;
            end
        end
    end

    assign word_out       = word_q;
    assign round_out      = round_q;
    assign state_out      = state_q;
    assign word_valid_out = (state_q == ST_RUN);
    assign busy_out       = (state_q == ST_RUN);
    assign done_out       = (state_q == ST_DONE);

endmodule
